fetch_stage: RTL and testbench

//   Instruction-fetch stage with IF/ID output register, directly upstream of Decode.

---
 rtl/fetch_stage.sv | 194 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage with an IF/ID output register, sitting directly
//   upstream of Decode. Holds the PC, issues one req/ack fetch at a time to
//   instruction memory, honours Decode stall and branch/jump redirect, and
//   uses a one-entry skid buffer for a fetch that returns while Decode stalls.
//
//   Optional feature macro: FETCH_STATS_EN
//     When defined, adds fetch_cnt (IF/ID loads) and flush_cnt (redirect
//     cycles) output counters. Functional behaviour is otherwise identical.
//
//   Ports
//     clk          in   1   clock, rising edge
//     rst_n        in   1   asynchronous, active-low reset
//     imem_req     out  1   fetch request, held until imem_ack
//     imem_addr    out  32  fetch address, stable while imem_req=1
//     imem_ack     in   1   memory accepted request, imem_rdata valid
//     imem_rdata   in   32  fetched instruction word
//     id_stall     in   1   Decode cannot accept; IF/ID outputs hold
//     redirect_en  in   1   branch/jump taken; flush and refetch
//     redirect_pc  in   32  redirect target (bits [1:0] forced to 00)
//     instruction  out  32  IF/ID instruction
//     pc_plus4     out  32  IF/ID address of instruction + 4
//     if_valid     out  1   IF/ID holds a live instruction
//     fetch_cnt    out  32  (FETCH_STATS_EN only) IF/ID load count
//     flush_cnt    out  32  (FETCH_STATS_EN only) redirect cycle count
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        id_stall,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instruction,
   output logic [31:0] pc_plus4,
   output logic        if_valid
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] pc;
   logic [31:0] pc_inc;
   logic [31:0] redirect_target;
   logic [31:0] hold_addr;
   logic        discard;
   logic [31:0] skid_instr;
   logic [31:0] skid_pc4;

   logic        busy;
   logic        full;
   logic        ack_live;
   logic        load_direct;
   logic        load_skid_in;
   logic        load_from_skid;

   // Masking with a constant keeps every redirect_pc bit in use while forcing
   // word alignment of the target.
   assign redirect_target = redirect_pc & ~32'h0000_0003;
   assign pc_inc          = pc + 32'd4;

   assign busy     = (state == BUSY);
   assign full     = (state == FULL);
   assign ack_live = busy && imem_ack;

   // A returning fetch is consumed only when it is not stale (discard) and no
   // redirect kills it in the same cycle. It goes straight to IF/ID when
   // Decode can take it, otherwise it parks in the skid buffer.
   assign load_direct    = ack_live && !discard && !redirect_en && (!if_valid || !id_stall);
   assign load_skid_in   = ack_live && !discard && !redirect_en && if_valid && id_stall;
   assign load_from_skid = full && !id_stall && !redirect_en;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; redirect always lands in BUSY at the target
   always_comb begin
      state_next = state;
      if (redirect_en) begin
         state_next = BUSY;
      end else begin
         case (state)
            IDLE:    state_next = BUSY;
            BUSY:    if (load_skid_in) state_next = FULL;
            FULL:    if (!id_stall) state_next = BUSY;
            default: state_next = IDLE;
         endcase
      end
   end

   // Output logic. While a stale request is still awaiting its ack the bus
   // keeps showing the old address even though pc already holds the target.
   always_comb begin
      imem_req  = busy;
      imem_addr = discard ? hold_addr : pc;
   end

   // PC, discard flag and the address of an abandoned in-flight request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= RESET_PC;
         discard   <= 1'b0;
         hold_addr <= 32'h0;
      end else begin
         if (redirect_en) begin
            pc <= redirect_target;
         end else if (load_direct || load_skid_in) begin
            pc <= pc_inc;
         end

         if (busy && redirect_en && !imem_ack) begin
            discard <= 1'b1;
         end else if (ack_live) begin
            discard <= 1'b0;
         end

         if (busy && redirect_en && !imem_ack && !discard) begin
            hold_addr <= pc;
         end
      end
   end

   // Skid buffer contents; occupancy is tracked by the FULL state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_instr <= 32'h0;
         skid_pc4   <= 32'h0;
      end else if (load_skid_in) begin
         skid_instr <= imem_rdata;
         skid_pc4   <= pc_inc;
      end
   end

   // IF/ID register; redirect flushes, otherwise hold unless a load occurs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instruction <= 32'h0;
         pc_plus4    <= 32'h0;
         if_valid    <= 1'b0;
      end else if (redirect_en) begin
         instruction <= 32'h0;
         if_valid    <= 1'b0;
      end else if (load_direct) begin
         instruction <= imem_rdata;
         pc_plus4    <= pc_inc;
         if_valid    <= 1'b1;
      end else if (load_from_skid) begin
         instruction <= skid_instr;
         pc_plus4    <= skid_pc4;
         if_valid    <= 1'b1;
      end
   end

`ifdef FETCH_STATS_EN
   // Statistics counters, free-running modulo 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt <= 32'h0;
         flush_cnt <= 32'h0;
      end else begin
         if (load_direct || load_from_skid) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if (redirect_en) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. The memory model returns the fetch
//   address as the instruction word, so every expected instruction and
//   pc_plus4 value below is a hand-computed constant.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_stall;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic [31:0] instruction;
   logic [31:0] pc_plus4;
   logic        if_valid;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_cnt;
   logic [31:0] flush_cnt;
`endif

   int checks;
   int failures;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .id_stall    (id_stall),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .instruction (instruction),
      .pc_plus4    (pc_plus4),
      .if_valid    (if_valid)
`ifdef FETCH_STATS_EN
      ,
      .fetch_cnt   (fetch_cnt),
      .flush_cnt   (flush_cnt)
`endif
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: the instruction word equals its own address
   assign imem_rdata = imem_addr;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, then wait until just after the next rising edge
   task automatic applyStimulus(input logic ack, input logic stall, input logic redir, input logic [31:0] rpc);
      imem_ack    = ack;
      id_stall    = stall;
      redirect_en = redir;
      redirect_pc = rpc;
      @(posedge clk);
      #1;
   endtask

   // Checks the IF/ID triple in one go
   task automatic checkIfId(input string tag, input logic valid, input logic [31:0] ins, input logic [31:0] pc4);
      checkOutput({tag, ".if_valid"}, {31'h0, if_valid}, {31'h0, valid});
      checkOutput({tag, ".instruction"}, instruction, ins);
      checkOutput({tag, ".pc_plus4"}, pc_plus4, pc4);
   endtask

   // Checks the memory request side
   task automatic checkReq(input string tag, input logic req, input logic [31:0] addr);
      checkOutput({tag, ".imem_req"}, {31'h0, imem_req}, {31'h0, req});
      if (req) checkOutput({tag, ".imem_addr"}, imem_addr, addr);
   endtask

   // Directed sequence
   initial begin
      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      imem_ack    = 1'b0;
      id_stall    = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = 32'h0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkIfId("reset", 1'b0, 32'h0, 32'h0);
      checkReq("reset", 1'b0, 32'h0);
      checkOutput("reset.imem_addr", imem_addr, 32'h0);
      rst_n = 1'b1;

      // Release: first request appears one cycle later
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkReq("first_req", 1'b1, 32'h0);
      checkIfId("first_req", 1'b0, 32'h0, 32'h0);

      // Streaming with ack every cycle
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("stream0", 1'b1, 32'h0, 32'h4);
      checkReq("stream0", 1'b1, 32'h4);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("stream1", 1'b1, 32'h4, 32'h8);
      checkReq("stream1", 1'b1, 32'h8);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("stream2", 1'b1, 32'h8, 32'hC);
      checkReq("stream2", 1'b1, 32'hC);

      // Stall for 3 cycles: 0xC goes to skid, req drops in FULL
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkIfId("stall0", 1'b1, 32'h8, 32'hC);
      checkReq("stall0", 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkIfId("stall1", 1'b1, 32'h8, 32'hC);
      checkReq("stall1", 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkIfId("stall2", 1'b1, 32'h8, 32'hC);

      // Release: skid contents delivered, fetch resumes at 0x10
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkIfId("unstall", 1'b1, 32'hC, 32'h10);
      checkReq("unstall", 1'b1, 32'h10);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("resume", 1'b1, 32'h10, 32'h14);
      checkReq("resume", 1'b1, 32'h14);

      // Redirect to 0x40 while the 0x14 request waits for its ack
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
      checkOutput("redir.if_valid", {31'h0, if_valid}, 32'h0);
      checkOutput("redir.instruction", instruction, 32'h0);
      checkReq("redir_hold0", 1'b1, 32'h14);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkReq("redir_hold1", 1'b1, 32'h14);
      checkOutput("redir_hold1.if_valid", {31'h0, if_valid}, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("redir_drop.if_valid", {31'h0, if_valid}, 32'h0);
      checkReq("redir_drop", 1'b1, 32'h40);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("redir_target", 1'b1, 32'h40, 32'h44);
      checkReq("redir_target", 1'b1, 32'h44);

      // Fill skid, then redirect together with stall
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkReq("fill_skid", 1'b0, 32'h0);
      checkIfId("fill_skid", 1'b1, 32'h40, 32'h44);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h103);
      checkOutput("flush.if_valid", {31'h0, if_valid}, 32'h0);
      checkOutput("flush.instruction", instruction, 32'h0);
      checkReq("flush", 1'b1, 32'h100);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkIfId("flush_load", 1'b1, 32'h100, 32'h104);
      checkReq("flush_load", 1'b1, 32'h104);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkIfId("flush_noskid", 1'b1, 32'h100, 32'h104);

      // Redirect in the ack cycle to the top word, then wrap
      applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      checkOutput("ackredir.if_valid", {31'h0, if_valid}, 32'h0);
      checkReq("ackredir", 1'b1, 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0);
      checkReq("wrap", 1'b1, 32'h0);

`ifdef FETCH_STATS_EN
      checkOutput("fetch_cnt", fetch_cnt, 32'd8);
      checkOutput("flush_cnt", flush_cnt, 32'd3);
`endif

      // Asynchronous reset in the middle of an outstanding request
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkReq("pre_reset", 1'b1, 32'h0);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst.imem_req", {31'h0, imem_req}, 32'h0);
      checkIfId("async_rst", 1'b0, 32'h0, 32'h0);
`ifdef FETCH_STATS_EN
      checkOutput("async_rst.fetch_cnt", fetch_cnt, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkReq("post_reset", 1'b1, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
